// File: rtl/memory_stage.sv
// Memory stage: EX/MEM register, data-memory req/ack controller with a wait
// watchdog, and MEM/WB register. Stalls upstream while an access is outstanding.
module memory_stage #(
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] FAULT_DATA = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        MemtoRegE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [3:0]  WA3E,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [31:0] ALUResultM,
  output logic        RegWriteM,
  output logic [3:0]  WA3M,
  output logic        StallM,
  output logic        MemFault,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic        regwrite_m_reg, memwrite_m_reg, memtoreg_m_reg;
  logic [31:0] alu_m_reg, wdata_m_reg;
  logic [3:0]  wa3_m_reg;

  logic        regwrite_w_reg, memtoreg_w_reg, fault_reg;
  logic [31:0] rdata_w_reg, alu_w_reg;
  logic [3:0]  wa3_w_reg;

  logic pending, timeout_hit, stall;

  assign pending     = memwrite_m_reg | memtoreg_m_reg;
  // An ack in the watchdog's final cycle takes precedence over the timeout.
  assign timeout_hit = (state_reg == S_WAIT) && (cnt_reg == CNT_LAST) && pending && !MemAck;
  assign stall       = pending && !MemAck && !timeout_hit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (pending && !MemAck) begin
          state_next = S_WAIT;
          cnt_next   = CW'(1);
        end
      end
      S_WAIT: begin
        if (MemAck || timeout_hit) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      fault_reg <= timeout_hit;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      regwrite_m_reg <= 1'b0;
      memwrite_m_reg <= 1'b0;
      memtoreg_m_reg <= 1'b0;
      alu_m_reg      <= '0;
      wdata_m_reg    <= '0;
      wa3_m_reg      <= '0;
    end else if (!stall) begin
      regwrite_m_reg <= RegWriteE;
      memwrite_m_reg <= MemWriteE;
      memtoreg_m_reg <= MemtoRegE;
      alu_m_reg      <= ALUResultE;
      wdata_m_reg    <= WriteDataE;
      wa3_m_reg      <= WA3E;
    end
  end

  // While stalled, a bubble goes to writeback; data fields keep their values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regwrite_w_reg <= 1'b0;
      memtoreg_w_reg <= 1'b0;
      rdata_w_reg    <= '0;
      alu_w_reg      <= '0;
      wa3_w_reg      <= '0;
    end else if (stall) begin
      regwrite_w_reg <= 1'b0;
      memtoreg_w_reg <= 1'b0;
    end else begin
      regwrite_w_reg <= regwrite_m_reg && !memwrite_m_reg && !(memtoreg_m_reg && timeout_hit);
      memtoreg_w_reg <= memtoreg_m_reg;
      alu_w_reg      <= alu_m_reg;
      wa3_w_reg      <= wa3_m_reg;
      if (memtoreg_m_reg && MemAck)
        rdata_w_reg <= MemRData;
      else if (memtoreg_m_reg && timeout_hit)
        rdata_w_reg <= FAULT_DATA;
    end
  end

  assign MemReq     = pending;
  assign MemWe      = memwrite_m_reg;
  assign MemAddr    = alu_m_reg;
  assign MemWData   = wdata_m_reg;
  assign ALUResultM = alu_m_reg;
  assign RegWriteM  = regwrite_m_reg;
  assign WA3M       = wa3_m_reg;
  assign StallM     = stall;
  assign MemFault   = fault_reg;
  assign RegWriteW  = regwrite_w_reg;
  assign MemtoRegW  = memtoreg_w_reg;
  assign ReadDataW  = rdata_w_reg;
  assign ALUOutW    = alu_w_reg;
  assign WA3W       = wa3_w_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: table of single-instruction vectors plus
// hand-written stall, timeout, back-to-back and reset sequences.
module tb_memory_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RegWriteE, MemWriteE, MemtoRegE;
  logic [31:0] ALUResultE, WriteDataE;
  logic [3:0]  WA3E;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData, ALUResultM;
  logic        RegWriteM;
  logic [3:0]  WA3M;
  logic        StallM, MemFault, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [3:0]  WA3W;

  int n_tests = 0;
  int n_fail  = 0;

  memory_stage #(.TIMEOUT(16), .FAULT_DATA(32'hDEADBEEF)) dut (
    .CLK(CLK), .RESET(RESET),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .MemAck(MemAck), .MemRData(MemRData),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .ALUResultM(ALUResultM), .RegWriteM(RegWriteM), .WA3M(WA3M),
    .StallM(StallM), .MemFault(MemFault),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WA3W(WA3W)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw, mw, m2r;
    logic [31:0] alu, wd;
    logic [3:0]  wa3;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req, exp_we, exp_stall;
    logic        exp_rww, exp_m2rw;
    logic [31:0] exp_rdw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_e(input logic rw, input logic mw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa3);
    RegWriteE = rw; MemWriteE = mw; MemtoRegE = m2r;
    ALUResultE = alu; WriteDataE = wd; WA3E = wa3;
  endtask

  task automatic bubble();
    drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  vec_t vecs[6];
  int   stall_cnt;
  logic ended;

  initial begin
    //        rw  mw  m2r alu            wd            wa3    ack   rdata          req we stall rww m2rw rdw
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'd3, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'd5, 1'b1, 32'hCAFE0001,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE0001};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h55, 4'd0, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE0001};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'd15, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE0001};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h77, 4'd6, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE0001};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 4'd9, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};

    RESET = 1'b1; MemAck = 1'b0; MemRData = 32'h0;
    bubble();
    next_cycle();
    next_cycle();
    @(negedge CLK);
    chk("reset_memreq",   32'(MemReq), 32'h0);
    chk("reset_stall",    32'(StallM), 32'h0);
    chk("reset_fault",    32'(MemFault), 32'h0);
    chk("reset_rww",      32'(RegWriteW), 32'h0);
    chk("reset_readdata", ReadDataW, 32'h0);
    chk("reset_aluw",     ALUOutW, 32'h0);
    next_cycle();
    RESET = 1'b0;

    // Single-instruction vectors, one at a time with bubbles around them
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive_e(vecs[i].rw, vecs[i].mw, vecs[i].m2r, vecs[i].alu, vecs[i].wd, vecs[i].wa3);
      MemAck = 1'b0;
      next_cycle();
      bubble();
      MemAck = vecs[i].ack; MemRData = vecs[i].rdata;
      @(negedge CLK);
      chk($sformatf("v%0d_memreq", i), 32'(MemReq), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_memwe", i),  32'(MemWe),  32'(vecs[i].exp_we));
      chk($sformatf("v%0d_stall", i),  32'(StallM), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d_aluM", i),   ALUResultM,  vecs[i].alu);
      chk($sformatf("v%0d_wa3M", i),   32'(WA3M),   32'(vecs[i].wa3));
      next_cycle();
      MemAck = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_rww", i),  32'(RegWriteW), 32'(vecs[i].exp_rww));
      chk($sformatf("v%0d_m2rw", i), 32'(MemtoRegW), 32'(vecs[i].exp_m2rw));
      chk($sformatf("v%0d_rdw", i),  ReadDataW,      vecs[i].exp_rdw);
      chk($sformatf("v%0d_aluw", i), ALUOutW,        vecs[i].alu);
      chk($sformatf("v%0d_wa3w", i), 32'(WA3W),      32'(vecs[i].wa3));
      $display("[TB] vector %0d applied", i);
    end

    // Store acked after 3 wait cycles
    next_cycle();
    drive_e(1'b0, 1'b1, 1'b0, 32'h200, 32'h55, 4'd0);
    next_cycle();
    bubble();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("st_stall", 32'(StallM), 32'h1);
      chk("st_addr",  MemAddr, 32'h200);
      chk("st_wdata", MemWData, 32'h55);
      chk("st_we",    32'(MemWe), 32'h1);
      chk("st_rww",   32'(RegWriteW), 32'h0);
      next_cycle();
    end
    MemAck = 1'b1;
    @(negedge CLK);
    chk("st_ack_stall", 32'(StallM), 32'h0);
    chk("st_ack_rww",   32'(RegWriteW), 32'h0);
    next_cycle();
    MemAck = 1'b0;
    @(negedge CLK);
    chk("st_done_req", 32'(MemReq), 32'h0);
    chk("st_done_rww", 32'(RegWriteW), 32'h0);
    $display("[TB] delayed store done");

    // Load never acked: watchdog fires
    next_cycle();
    drive_e(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 4'd7);
    next_cycle();
    bubble();
    stall_cnt = 0; ended = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (StallM) stall_cnt++;
      else begin ended = 1'b1; break; end
      next_cycle();
    end
    chk("to_ended",      32'(ended), 32'h1);
    chk("to_stall_cnt",  32'(stall_cnt), 32'd15);
    chk("to_fault_early", 32'(MemFault), 32'h0);
    next_cycle();
    @(negedge CLK);
    chk("to_fault",    32'(MemFault), 32'h1);
    chk("to_readdata", ReadDataW, 32'hDEADBEEF);
    chk("to_rww",      32'(RegWriteW), 32'h0);
    chk("to_wa3w",     32'(WA3W), 32'd7);
    next_cycle();
    @(negedge CLK);
    chk("to_fault_pulse", 32'(MemFault), 32'h0);
    chk("to_resume_req",  32'(MemReq), 32'h0);
    $display("[TB] timeout load done, stall cycles %0d", stall_cnt);

    // Ack arriving in the watchdog's final cycle completes normally
    next_cycle();
    drive_e(1'b1, 1'b0, 1'b1, 32'h304, 32'h0, 4'd8);
    next_cycle();
    bubble();
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      chk("late_stall", 32'(StallM), 32'h1);
      next_cycle();
    end
    MemAck = 1'b1; MemRData = 32'h0BADF00D;
    @(negedge CLK);
    chk("late_ack_stall", 32'(StallM), 32'h0);
    next_cycle();
    MemAck = 1'b0;
    @(negedge CLK);
    chk("late_fault",    32'(MemFault), 32'h0);
    chk("late_readdata", ReadDataW, 32'h0BADF00D);
    chk("late_rww",      32'(RegWriteW), 32'h1);
    $display("[TB] ack on final watchdog cycle done");

    // Back-to-back loads, each acked after one wait cycle
    next_cycle();
    drive_e(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 4'd1);
    next_cycle();
    drive_e(1'b1, 1'b0, 1'b1, 32'h404, 32'h0, 4'd2);
    MemAck = 1'b0;
    @(negedge CLK);
    chk("b2b_req0",   32'(MemReq), 32'h1);
    chk("b2b_stall0", 32'(StallM), 32'h1);
    next_cycle();
    MemAck = 1'b1; MemRData = 32'hA1A1A1A1;
    @(negedge CLK);
    chk("b2b_stall1", 32'(StallM), 32'h0);
    next_cycle();
    bubble();
    MemAck = 1'b0;
    @(negedge CLK);
    chk("b2b_req2",   32'(MemReq), 32'h1);
    chk("b2b_addr2",  MemAddr, 32'h404);
    chk("b2b_rdw1",   ReadDataW, 32'hA1A1A1A1);
    chk("b2b_wa3w1",  32'(WA3W), 32'd1);
    chk("b2b_rww1",   32'(RegWriteW), 32'h1);
    next_cycle();
    MemAck = 1'b1; MemRData = 32'hB2B2B2B2;
    next_cycle();
    MemAck = 1'b0;
    @(negedge CLK);
    chk("b2b_req4",  32'(MemReq), 32'h0);
    chk("b2b_rdw2",  ReadDataW, 32'hB2B2B2B2);
    chk("b2b_wa3w2", 32'(WA3W), 32'd2);
    $display("[TB] back-to-back loads done");

    // Reset during an outstanding load
    next_cycle();
    drive_e(1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 4'd4);
    next_cycle();
    bubble();
    next_cycle();
    next_cycle();
    RESET = 1'b1;
    next_cycle();
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_req",   32'(MemReq), 32'h0);
    chk("rst_stall", 32'(StallM), 32'h0);
    chk("rst_rww",   32'(RegWriteW), 32'h0);
    chk("rst_fault", 32'(MemFault), 32'h0);
    next_cycle();
    MemAck = 1'b1; MemRData = 32'h99999999;
    @(negedge CLK);
    chk("rst_late_ack_req", 32'(MemReq), 32'h0);
    next_cycle();
    MemAck = 1'b0;
    @(negedge CLK);
    chk("rst_late_ack_rdw", ReadDataW, 32'h0);
    chk("rst_late_ack_rww", 32'(RegWriteW), 32'h0);
    chk("rst_late_fault",   32'(MemFault), 32'h0);
    $display("[TB] reset during wait done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory stage of the 5-stage pipeline. It sits directly downstream of the execute stage and directly upstream of writeback.
- Contains three parts:
  - the EX/MEM pipeline register;
  - a data-memory access controller with a req/ack handshake and a wait-timeout watchdog;
  - the MEM/WB pipeline register.
- Stalls the front of the pipeline while a data access is outstanding.

Parameters:
- TIMEOUT, 16, maximum wait cycles for MemAck before the access is aborted (must be ≥2).
- FAULT_DATA, 32'hDEADBEEF, value returned as ReadDataW on an aborted load.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- RegWriteE  in  1  register write enable from execute (already condition-gated)
- MemWriteE  in  1  store enable from execute (already condition-gated)
- MemtoRegE  in  1  load select from execute
- ALUResultE  in  32  address / ALU result
- WriteDataE  in  32  store data
- WA3E  in  4  destination register
- MemAck  in  1  data memory acknowledge
- MemRData  in  32  data memory read data, valid when MemAck=1
- MemReq  out  1  data memory request
- MemWe  out  1  request is a store
- MemAddr  out  32  request address
- MemWData  out  32  store data
- ALUResultM  out  32  EX/MEM ALU result, used by execute forwarding
- RegWriteM  out  1  EX/MEM register-write, used by the hazard unit
- WA3M  out  4  EX/MEM destination, used by the hazard unit
- StallM  out  1  holds the fetch, decode and execute stages and the EX/MEM register
- MemFault  out  1  one-cycle pulse on access timeout
- RegWriteW  out  1  MEM/WB register-write
- MemtoRegW  out  1  MEM/WB load select
- ReadDataW  out  32  MEM/WB load data
- ALUOutW  out  32  MEM/WB ALU result
- WA3W  out  4  MEM/WB destination

Behaviour:
- Reset, synchronous, active-high:
  - Every registered output and control bit clears to 0: all M and W fields, wait counter, MemFault.
  - State is IDLE.
  - MemReq, MemWe and StallM read 0 in the cycle after reset.
  - RESET dominates every other event, including an outstanding access: the access is dropped and no fault is raised.
- EX/MEM register:
  - Loads all E inputs at the rising edge when StallM=0.
  - Holds its value when StallM=1.
- Pending access: pending = (MemWriteM | MemtoRegM) in the current EX/MEM contents, with state IDLE or WAIT.
- Memory request outputs:
  - MemReq = pending.
  - MemWe = MemWriteM.
  - MemAddr = ALUResultM, MemWData = WriteDataM.
  - All four are driven from registers only, so they stay stable for the whole request.
- StallM = pending & ~MemAck & ~timeout_hit.
- FSM states:
  - IDLE: if pending & ~MemAck, go to WAIT and set the counter to 1. If pending & MemAck, this is a zero-wait access: no stall, stay in IDLE.
  - WAIT: on MemAck, go to IDLE. Otherwise the counter increments. When counter = TIMEOUT-1 with no ack, timeout_hit=1 for that cycle: StallM drops, MemFault pulses at the next edge, and the FSM returns to IDLE.
- MEM/WB register, updated when StallM=0:
  - ALUOutW, WA3W and MemtoRegW take their M-stage values.
  - ReadDataW takes MemRData on an acked load, FAULT_DATA on a timed-out load, and holds otherwise.
  - RegWriteW = RegWriteM & ~(timed-out load).
- MEM/WB register when StallM=1: a bubble is inserted (RegWriteW=0, MemtoRegW=0); the other fields hold.
- Stores never set RegWriteW.
- A timed-out store is discarded: MemFault pulses and no write is assumed.
- MemAck with no pending access is ignored.
- An ack arriving in the same cycle that timeout_hit fires wins: the access completes normally and there is no fault.
- Latency:
  - Non-memory instruction: 1 cycle through each register.
  - Zero-wait access: 0 stall cycles.
  - Access acked N cycles after MemReq rises: N stall cycles.
- Back-to-back memory operations: the second instruction's MemReq rises in the cycle after the first one's ack edge, with no idle gap.

Test Plan:
- ADD with RegWriteE=1, ALUResultE=32'h0000_0010, WA3E=3, no memory op → 2 cycles later RegWriteW=1, ALUOutW=32'h10, WA3W=3; StallM stays 0.
- Load from 32'h100 with MemAck tied high, MemRData=32'hCAFE0001 → MemReq=1 and MemWe=0 for 1 cycle, StallM=0, next cycle ReadDataW=32'hCAFE0001 and RegWriteW=1.
- Store of 32'h55 to 32'h200 with MemAck delayed 3 cycles:
  - StallM=1 for exactly 3 cycles; MemAddr/MemWData are stable at 32'h200/32'h55 throughout.
  - RegWriteW=0 on every cycle, including the bubbles.
- Load with MemAck never asserted, TIMEOUT=16 → StallM=1 for 15 cycles, then one MemFault pulse; ReadDataW=32'hDEADBEEF, RegWriteW=0; the pipeline resumes.
- Two consecutive loads, each acked after 1 wait cycle → two separate MemReq windows with no idle cycle between them; ReadDataW values appear in order.
- RESET asserted while in WAIT during a load → next cycle MemReq=0, StallM=0, RegWriteW=0, MemFault=0; a later MemAck is ignored.
